// File: rtl/scc_control_fsm.sv
// scc_control_fsm: multi-cycle sequencer for the SCC core.
//
// Fetches an instruction over the imem req/ack handshake into the instruction
// register, then steps it through DECODE, EXECUTE, optional MEMORY and
// WRITEBACK. It issues the PC, register-file, flag and data-memory strobes,
// evaluates branch conditions, stops on HALT, and raises a sticky illegal flag
// on undefined encodings or bus timeouts. All outputs are Moore outputs,
// decoded from the state and instruction registers only.
//
// Parameters:
//   ACK_TIMEOUT  max cycles spent waiting for imem_ack/dmem_ack (0 = no limit)
//   AUTOSTART    1 = leave IDLE right after reset without waiting for start
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   start_i                      level; leave IDLE when 1
//   imem_req_o / imem_ack_i      fetch handshake, imem_rdata_i = fetched word
//   dmem_req_o / dmem_ack_i      data handshake, dmem_we_o = 1 for a store
//   flags_nzcv_i                 current {N,Z,C,V}
//   ir_o                         instruction register, drives the decoder
//   alu_en_o, rf_we_o, flags_we_o, pc_we_o, pc_src_o   datapath strobes
//   state_o, halted_o, illegal_o status
//   cyc_cnt_o, instret_cnt_o     performance counters
//
// Optional feature macro: SCC_PERF_CNT_EN builds the two performance counters;
// when it is undefined the counter ports are tied to 0 and no flops are built.
module scc_control_fsm #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned AUTOSTART   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ack_i,
    output logic        imem_req_o,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic [3:0]  flags_nzcv_i,
    output logic [31:0] ir_o,
    output logic        alu_en_o,
    output logic        rf_we_o,
    output logic        flags_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic [2:0]  state_o,
    output logic        halted_o,
    output logic        illegal_o,
    output logic [31:0] cyc_cnt_o,
    output logic [31:0] instret_cnt_o
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        OpData, OpLoad, OpStore, OpBranch, OpBcond, OpBreg, OpNop, OpUndef, OpHalt
    } op_e;

    localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);
    localparam bit TmoEn     = (ACK_TIMEOUT != 0);
    localparam bit AutoStart = (AUTOSTART != 0);

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic            taken_q, taken_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            illegal_q, illegal_d;

    op_e  op;
    logic cond_true;
    logic fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags_nzcv_i;

    // Instruction class decode from the held instruction word.
    always_comb begin
        op = OpUndef;
        if (!ir_q[31]) begin
            op = OpData;
        end else if (!ir_q[30]) begin
            op = ir_q[25] ? OpStore : OpLoad;
        end else if (ir_q[28:25] == 4'b0000) begin
            op = OpBranch;
        end else if (ir_q[28:25] == 4'b0001) begin
            op = OpBcond;
        end else if (ir_q[28:25] == 4'b0010) begin
            op = OpBreg;
        end else if (ir_q[27]) begin
            op = OpNop;
        end else if (ir_q[28]) begin
            op = OpHalt;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        unique case (ir_q[24:21])
            4'h0: cond_true = fz;
            4'h1: cond_true = !fz;
            4'h2: cond_true = fc;
            4'h3: cond_true = !fc;
            4'h4: cond_true = fn;
            4'h5: cond_true = !fn;
            4'h6: cond_true = fv;
            4'h7: cond_true = !fv;
            4'h8: cond_true = fc && !fz;
            4'h9: cond_true = !fc || fz;
            4'hA: cond_true = (fn == fv);
            4'hB: cond_true = (fn != fv);
            4'hC: cond_true = !fz && (fn == fv);
            4'hD: cond_true = fz || (fn != fv);
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-state logic. The timeout counter defaults to 0, so it is clear on
    // every entry to FETCH/MEMORY and only counts while an ack is awaited.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        taken_d   = taken_q;
        tmo_d     = '0;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (start_i || AutoStart) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = StDecode;
                end else if (TmoEn && (tmo_q == TmoLast)) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StDecode: begin
                // Branch outcome is captured here so pc_src stays a pure
                // function of registered state during EXECUTE.
                taken_d = cond_true;
                state_d = StExecute;
            end
            StExecute: begin
                unique case (op)
                    OpData:  state_d = StWriteback;
                    OpLoad,
                    OpStore: state_d = StMemory;
                    OpHalt:  state_d = StHalt;
                    OpUndef: begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMemory: begin
                if (dmem_ack_i) begin
                    state_d = ir_q[25] ? StFetch : StWriteback;
                end else if (TmoEn && (tmo_q == TmoLast)) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            taken_q   <= 1'b0;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore output decode.
    always_comb begin
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        alu_en_o   = 1'b0;
        rf_we_o    = 1'b0;
        flags_we_o = 1'b0;
        pc_we_o    = 1'b0;
        pc_src_o   = 2'b00;
        halted_o   = 1'b0;
        unique case (state_q)
            StFetch: imem_req_o = 1'b1;
            StExecute: begin
                alu_en_o = 1'b1;
                pc_we_o  = (op != OpHalt);
                unique case (op)
                    OpBranch: pc_src_o = 2'b01;
                    OpBcond:  pc_src_o = taken_q ? 2'b01 : 2'b00;
                    OpBreg:   pc_src_o = 2'b10;
                    default:  pc_src_o = 2'b00;
                endcase
            end
            StMemory: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = ir_q[25];
            end
            StWriteback: begin
                rf_we_o    = 1'b1;
                flags_we_o = ir_q[29] & ir_q[28];
            end
            StHalt:  halted_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign ir_o      = ir_q;
    assign illegal_o = illegal_q;

`ifdef SCC_PERF_CNT_EN
    logic [31:0] cyc_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != StIdle && state_q != StHalt) cyc_q <= cyc_q + 32'd1;
            if (state_d == StFetch &&
                (state_q == StExecute || state_q == StMemory || state_q == StWriteback)) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cyc_cnt_o     = cyc_q;
    assign instret_cnt_o = instret_q;
`else
    assign cyc_cnt_o     = '0;
    assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_scc_control_fsm.sv
// Self-checking bench for scc_control_fsm: directed scenarios plus randomized
// instruction streams with random wait states, checked against an
// instruction-level reference model.
module tb_scc_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [3:0]  flags = '0;
    logic        imem_req, dmem_req, dmem_we, alu_en, rf_we, flags_we, pc_we;
    logic        halted, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] ir, cyc_cnt, instret_cnt;

    scc_control_fsm #(.ACK_TIMEOUT(16), .AUTOSTART(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .imem_rdata_i  (imem_rdata),
        .imem_ack_i    (imem_ack),
        .imem_req_o    (imem_req),
        .dmem_ack_i    (dmem_ack),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .flags_nzcv_i  (flags),
        .ir_o          (ir),
        .alu_en_o      (alu_en),
        .rf_we_o       (rf_we),
        .flags_we_o    (flags_we),
        .pc_we_o       (pc_we),
        .pc_src_o      (pc_src),
        .state_o       (state),
        .halted_o      (halted),
        .illegal_o     (illegal),
        .cyc_cnt_o     (cyc_cnt),
        .instret_cnt_o (instret_cnt)
    );

    always #5 clk = ~clk;

    localparam int KData = 0, KLoad = 1, KStore = 2, KB = 3, KBcond = 4;
    localparam int KBr = 5, KNop = 6, KUndef = 7, KHalt = 8;

    int          n_total = 0;
    int          n_pass = 0;
    logic        ill_exp = 1'b0;
    int unsigned cyc_exp = 0;
    int unsigned ret_exp = 0;

    logic [13:0] obs;
    assign obs = {state, imem_req, dmem_req, dmem_we, alu_en, rf_we, flags_we, pc_we, pc_src,
                  halted, illegal};

    function automatic logic [13:0] pk(input logic [2:0] st, input logic ireq, input logic dreq,
                                       input logic dwe, input logic alu, input logic rf,
                                       input logic fw, input logic pcwe, input logic [1:0] src,
                                       input logic hlt, input logic ill);
        return {st, ireq, dreq, dwe, alu, rf, fw, pcwe, src, hlt, ill};
    endfunction

    function automatic int kind_of(input logic [31:0] w);
        if (!w[31]) return KData;
        if (!w[30]) return w[25] ? KStore : KLoad;
        if (w[28:25] == 4'd0) return KB;
        if (w[28:25] == 4'd1) return KBcond;
        if (w[28:25] == 4'd2) return KBr;
        if (w[27]) return KNop;
        if (w[28]) return KHalt;
        return KUndef;
    endfunction

    // Conditions come in complementary pairs: odd codes invert the even one.
    function automatic logic taken(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, b;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ cond[0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int cls;
        w = $urandom;
        cls = $urandom_range(0, 6);
        case (cls)
            0: w[31] = 1'b0;
            1: w[31:30] = 2'b10;
            2: begin w[31:30] = 2'b11; w[28:25] = 4'b0000; end
            3: begin w[31:30] = 2'b11; w[28:25] = 4'b0001; end
            4: begin w[31:30] = 2'b11; w[28:25] = 4'b0010; end
            5: begin w[31:30] = 2'b11; w[27] = 1'b1; end
            default: begin w[31:30] = 2'b11; w[28:25] = 4'b0011; end
        endcase
        return w;
    endfunction

    task automatic do_reset();
        logic [109:0] all;
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #2;
        all = {obs, ir, cyc_cnt, instret_cnt};
        n_total++;
        if (all !== '0) $display("FAIL reset_outputs: got %h want 0", all);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ill_exp = 1'b0; cyc_exp = 0; ret_exp = 0;
    endtask

    task automatic go_fetch();
        imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if (state !== 3'd1) $display("FAIL idle_to_fetch: got state %0d want 1", state);
        else n_pass++;
    endtask

    // Drives one instruction from FETCH to its end, checking every cycle.
    task automatic run_instr(input logic [31:0] w, input logic [3:0] nzcv, input int wi,
                             input int wd);
        int          kd;
        logic [1:0]  src;
        logic [13:0] e;
        kd = kind_of(w);
        if (kd == KB) src = 2'b01;
        else if (kd == KBr) src = 2'b10;
        else if (kd == KBcond && taken(w[24:21], nzcv)) src = 2'b01;
        else src = 2'b00;
        flags = nzcv;
        for (int k = 0; k <= wi; k++) begin
            e = pk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ill_exp);
            n_total++;
            if (obs !== e) $display("FAIL fetch %h: got %h want %h", w, obs, e);
            else n_pass++;
            imem_ack = (k == wi);
            imem_rdata = (k == wi) ? w : $urandom;
            dmem_ack = 1'($urandom_range(0, 1));
            cyc_exp++;
            @(posedge clk); #1;
        end
        imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        e = pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ill_exp);
        n_total++;
        if (obs !== e) $display("FAIL decode %h: got %h want %h", w, obs, e);
        else n_pass++;
        n_total++;
        if (ir !== w) $display("FAIL ir: got %h want %h", ir, w);
        else n_pass++;
        cyc_exp++;
        @(posedge clk); #1;
        imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
        e = pk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, kd != KHalt, src, 1'b0, ill_exp);
        n_total++;
        if (obs !== e) $display("FAIL execute %h: got %h want %h", w, obs, e);
        else n_pass++;
        cyc_exp++;
        @(posedge clk); #1;
        if (kd == KUndef) ill_exp = 1'b1;
        if (kd == KHalt) begin
            imem_ack = 1'b0; dmem_ack = 1'b0;
            e = pk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, ill_exp);
            n_total++;
            if (obs !== e) $display("FAIL halt_entry %h: got %h want %h", w, obs, e);
            else n_pass++;
            return;
        end
        if (kd == KLoad || kd == KStore) begin
            for (int k = 0; k <= wd; k++) begin
                e = pk(3'd4, 1'b0, 1'b1, kd == KStore, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                       ill_exp);
                n_total++;
                if (obs !== e) $display("FAIL memory %h: got %h want %h", w, obs, e);
                else n_pass++;
                dmem_ack = (k == wd);
                imem_ack = 1'($urandom_range(0, 1));
                cyc_exp++;
                @(posedge clk); #1;
            end
            imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
        end
        if (kd == KData || kd == KLoad) begin
            e = pk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w[29] & w[28], 1'b0, 2'b00, 1'b0,
                   ill_exp);
            n_total++;
            if (obs !== e) $display("FAIL writeback %h: got %h want %h", w, obs, e);
            else n_pass++;
            cyc_exp++;
            @(posedge clk); #1;
        end
        ret_exp++;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        n_total++;
        if (state !== 3'd1) $display("FAIL back_to_fetch %h: got state %0d want 1", w, state);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        go_fetch();
        @(posedge clk); #1;
        imem_ack = 1'b1; imem_rdata = 32'h72530000;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        do_reset();
    endtask

    task automatic test_idle();
        logic [13:0] e;
        e = '0;
        for (int k = 0; k < 5; k++) begin
            imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_total++;
            if (obs !== e || ir !== '0) $display("FAIL idle_hold: got %h want %h", obs, e);
            else n_pass++;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_adds();
        do_reset();
        go_fetch();
        run_instr(32'h72530000, 4'h0, 0, 0);
        run_instr(32'h72530000, 4'hF, 2, 0);
    endtask

    task automatic test_load_store();
        run_instr(32'h80400004, 4'h0, 0, 3);
        run_instr(32'h82400004, 4'h0, 1, 2);
        run_instr(32'hB0400004, 4'h0, 0, 0);
    endtask

    task automatic test_branches();
        run_instr(32'hC2000010, 4'b0100, 0, 0);
        run_instr(32'hC2000010, 4'b0000, 0, 0);
        run_instr(32'hC3C00010, 4'($urandom), 0, 0);
        run_instr(32'hC3E00010, 4'($urandom), 0, 0);
        run_instr(32'hC0000000, 4'h0, 0, 0);
        run_instr(32'hC4000000, 4'h0, 0, 0);
        run_instr(32'hC8000000, 4'h0, 0, 0);
    endtask

    task automatic test_undefined();
        run_instr(32'hC6000000, 4'h0, 0, 0);
        run_instr(32'h72530000, 4'h0, 0, 0);
    endtask

    task automatic test_halt();
        logic [13:0] e;
        run_instr(32'hD0000000, 4'h0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            start = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            e = pk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, ill_exp);
            n_total++;
            if (obs !== e) $display("FAIL halt_sticky: got %h want %h", obs, e);
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_timeout();
        logic [13:0] e;
        do_reset();
        go_fetch();
        for (int k = 0; k < 16; k++) begin
            e = pk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
            n_total++;
            if (obs !== e) $display("FAIL timeout_wait %0d: got %h want %h", k, obs, e);
            else n_pass++;
            imem_ack = 1'b0; dmem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        e = pk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        n_total++;
        if (obs !== e) $display("FAIL timeout_halt: got %h want %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_perf();
        logic [31:0] want_cyc, want_ret;
        do_reset();
        go_fetch();
        for (int k = 0; k < 3; k++) run_instr(32'h72530000, 4'h0, 0, 0);
        run_instr(32'hD0000000, 4'h0, 0, 0);
`ifdef SCC_PERF_CNT_EN
        want_cyc = 32'd15; want_ret = 32'd3;
`else
        want_cyc = 32'd0; want_ret = 32'd0;
`endif
        n_total++;
        if (cyc_cnt !== want_cyc) $display("FAIL perf_cyc: got %0d want %0d", cyc_cnt, want_cyc);
        else n_pass++;
        n_total++;
        if (instret_cnt !== want_ret)
            $display("FAIL perf_instret: got %0d want %0d", instret_cnt, want_ret);
        else n_pass++;
        do_reset();
        go_fetch();
        run_instr(32'h72530000, 4'h0, 0, 0);
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] want_cyc, want_ret;
        do_reset();
        go_fetch();
        for (int k = 0; k < 30; k++) begin
            run_instr(rand_instr(), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef SCC_PERF_CNT_EN
        want_cyc = cyc_exp; want_ret = ret_exp;
`else
        want_cyc = 32'd0; want_ret = 32'd0;
`endif
        n_total++;
        if (cyc_cnt !== want_cyc) $display("FAIL rand_cyc: got %0d want %0d", cyc_cnt, want_cyc);
        else n_pass++;
        n_total++;
        if (instret_cnt !== want_ret)
            $display("FAIL rand_instret: got %0d want %0d", instret_cnt, want_ret);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_adds();
        test_load_store();
        test_branches();
        test_undefined();
        test_halt();
        test_timeout();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
